// File: rtl/sw_debounce.sv
// Debouncer for a bank of slide switches: two-flop synchronizer, shared sample-tick
// prescaler, and a per-bit stability counter that accepts a new level only after it persists.
module sw_debounce #(
  parameter int WIDTH        = 18,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_sw,
  output logic [WIDTH-1:0] out_sw,
  output logic [WIDTH-1:0] changed
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_TICKS) + 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]            sync1_q, sync1_d;
  logic [WIDTH-1:0]            sync2_q, sync2_d;
  logic [PRE_W-1:0]            pre_q, pre_d;
  logic [WIDTH-1:0]            out_q, out_d;
  logic [WIDTH-1:0]            changed_q, changed_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                        tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pre_q     <= '0;
      out_q     <= '0;
      changed_q <= '0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pre_q     <= pre_d;
      out_q     <= out_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    sync1_d   = in_sw;
    sync2_d   = sync1_q;
    tick      = (pre_q == PRE_LAST);
    pre_d     = tick ? '0 : pre_q + PRE_W'(1);
    out_d     = out_q;
    changed_d = '0;
    cnt_d     = cnt_q;
    // Any cycle the synchronized level agrees with the output throws away partial progress.
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          out_d[i]     = sync2_q[i];
          cnt_d[i]     = '0;
          changed_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign out_sw  = out_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: table-driven vectors on an 18-bit, TICK_DIV=1,
// STABLE_TICKS=4 instance, plus hand sequences for reset corners and a slow-tick instance.
module tb_sw_debounce;

  typedef struct {
    logic [17:0] inSw;
    logic [17:0] expOut;
    logic [17:0] expChg;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] inSw = '0;
  logic [17:0] outSw;
  logic [17:0] chg;
  logic [1:0]  inSw2 = '0;
  logic [1:0]  outSw2;
  logic [1:0]  chg2;

  int   nChecks = 0;
  int   nFail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  sw_debounce #(.WIDTH(18), .TICK_DIV(1), .STABLE_TICKS(4)) u_dut (
    .clk(clk), .reset(reset), .in_sw(inSw), .out_sw(outSw), .changed(chg)
  );

  sw_debounce #(.WIDTH(2), .TICK_DIV(5), .STABLE_TICKS(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_sw(inSw2), .out_sw(outSw2), .changed(chg2)
  );

  task automatic checkOutput(input string name, input logic [17:0] act, input logic [17:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [17:0] i, input logic [17:0] o, input logic [17:0] c);
    vec_t v;
    v.inSw = i; v.expOut = o; v.expChg = c;
    vecs.push_back(v);
  endtask

  // A clean change: five edges of no movement, acceptance on the sixth, then quiet.
  task automatic addToggle(input logic [17:0] newIn, input logic [17:0] prevOut);
    for (int k = 0; k < 5; k++) addVec(newIn, prevOut, 18'h0);
    addVec(newIn, newIn, newIn ^ prevOut);
    addVec(newIn, newIn, 18'h0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    inSw = v.inSw;
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("vec%0d out_sw", idx), outSw, v.expOut);
    checkOutput($sformatf("vec%0d changed", idx), chg, v.expChg);
  endtask

  task automatic waitTick(output int cycles, output bit found);
    cycles = 0;
    found  = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      cycles++;
      if (u_dut2.tick) found = 1'b1;
    end
  endtask

  // Release reset and expect the held input to be accepted exactly on the sixth edge.
  task automatic checkAfterRelease(input string tag, input logic [17:0] level);
    int pulses = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("%s edge%0d out_sw", tag, k), outSw, (k >= 6) ? level : 18'h0);
      if (chg != 18'h0) pulses++;
    end
    checkOutput($sformatf("%s changed pulses", tag), 18'(pulses), 18'd1);
  endtask

  initial begin
    int  cyc;
    bit  found;

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) addVec(18'h00008, 18'h0, 18'h0);
      for (int k = 0; k < 3; k++) addVec(18'h00000, 18'h0, 18'h0);
    end
    addToggle(18'h00001, 18'h00000);
    addToggle(18'h00000, 18'h00001);
    addToggle(18'h3FFFF, 18'h00000);
    addToggle(18'h00000, 18'h3FFFF);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_sw", outSw, 18'h0);
    checkOutput("reset changed", chg, 18'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Reset two counts into a pending change on bit 7 must discard it.
    inSw = 18'h00080;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("bit7 pre-reset out_sw", outSw, 18'h0);
    end
    reset = 1'b1;
    #1;
    checkOutput("bit7 in reset out_sw", outSw, 18'h0);
    checkOutput("bit7 in reset changed", chg, 18'h0);
    @(posedge clk);
    checkAfterRelease("bit7", 18'h00080);

    // Asynchronous clear of an accepted value, then static pattern accepted after release.
    @(negedge clk);
    reset = 1'b1;
    inSw  = 18'h2A5A5;
    #1;
    checkOutput("async clear out_sw", outSw, 18'h0);
    @(posedge clk);
    checkAfterRelease("pattern", 18'h2A5A5);
    inSw = 18'h0;

    waitTick(cyc, found);
    checkOutput("first tick found", 18'(found), 18'd1);
    waitTick(cyc, found);
    checkOutput("tick spacing a", 18'(cyc), 18'd5);
    waitTick(cyc, found);
    checkOutput("tick spacing b", 18'(cyc), 18'd5);
    @(posedge clk);
    @(negedge clk);
    inSw2 = 2'b01;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("slow edge%0d out_sw", k), 18'(outSw2), (k >= 10) ? 18'd1 : 18'd0);
      checkOutput($sformatf("slow edge%0d changed", k), 18'(chg2), (k == 10) ? 18'd1 : 18'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 18, number of independent switch inputs.
REQ-002 Parameter TICK_DIV, default 50000, clock cycles per sample tick (1 ms at 50 MHz).
REQ-003 Parameter STABLE_TICKS, default 10, consecutive ticks a new level must persist before acceptance.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_sw  input  WIDTH  raw, asynchronous, bouncing slide-switch levels from the board pins.
REQ-007 out_sw  output  WIDTH  debounced levels; drives the PIO in_port of the switch peripheral.
REQ-008 changed  output  WIDTH  per-bit one-cycle pulse marking the cycle out_sw[i] toggled.

Function
REQ-009 in_sw SHALL pass through a two-flop synchronizer (sync1, sync2) per bit before any other use.
REQ-010 A prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert internal tick for exactly the one cycle where count equals TICK_DIV-1; TICK_DIV=1 gives tick every cycle.
REQ-011 Each bit SHALL own a saturating-free counter of width clog2(STABLE_TICKS)+1, independent of all other bits.
REQ-012 Every cycle where sync2[i] equals out_sw[i], counter[i] SHALL clear to 0, regardless of tick.
REQ-013 On tick with sync2[i] != out_sw[i] and counter[i] < STABLE_TICKS-1: counter[i] increments.
REQ-014 On tick with sync2[i] != out_sw[i] and counter[i] == STABLE_TICKS-1: out_sw[i] <= sync2[i], counter[i] <= 0, changed[i] <= 1.
REQ-015 changed[i] SHALL be 0 in every cycle other than the one following the REQ-014 edge; it is registered, aligned with the out_sw[i] update.
REQ-016 A bounce (sync2[i] returning to out_sw[i]) before acceptance SHALL discard progress; out_sw[i] never toggles on pulses shorter than STABLE_TICKS ticks.
REQ-017 Latency with TICK_DIV=1: a clean level change set up before edge 1 SHALL appear on out_sw at edge 2+STABLE_TICKS; general worst case 2+STABLE_TICKS*TICK_DIV cycles.
REQ-018 Multiple bits SHALL be able to toggle in the same cycle; changed then carries all of them.
REQ-019 STABLE_TICKS >= 1 and TICK_DIV >= 1 are legal; STABLE_TICKS=1 accepts at the first tick after synchronization.
REQ-020 No combinational path SHALL exist from in_sw to out_sw or changed.

Reset
REQ-021 While reset is high: sync1, sync2, out_sw, changed, all counters and the prescaler SHALL be 0, asynchronously.
REQ-022 After reset deassertion, bits whose in_sw is high SHALL be accepted through the normal debounce path (no reset-time bypass), yielding one changed pulse each.
REQ-023 Reset asserted mid-count SHALL abandon the pending change; after release the count restarts from 0.

Verification (WIDTH=18, TICK_DIV=1, STABLE_TICKS=4 unless stated)
REQ-024 in_sw 0 -> 0x00001 held clean -> out_sw = 0x00001 exactly 6 edges later, changed = 0x00001 for one cycle, then 0.
REQ-025 in_sw[3] pulses high for 3 cycles then low, repeated 5 times -> out_sw stays 0x00000, changed never asserts.
REQ-026 in_sw 0 -> 0x3FFFF in one cycle -> all 18 bits of out_sw and changed assert on the same edge; return to 0 -> matching falling toggle.
REQ-027 TICK_DIV=5, STABLE_TICKS=2: bit 0 raised just after a tick -> out_sw[0] rises on the second tick following synchronization, not before; tick spacing measured as 5 cycles.
REQ-028 Reset asserted 2 cycles into a 4-tick count on bit 7, released with in_sw[7] still high -> out_sw[7] rises 6 edges after release, single changed pulse.
REQ-029 Reset released with in_sw = 0x2A5A5 static -> out_sw = 0x2A5A5 after 6 edges, changed = 0x2A5A5 for one cycle.
